// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the parameterised serial pattern detector.
// Imported by seq_det_hist and seq_det_param.
package seq_det_pkg;

   localparam int DEF_MAX_LEN = 8;
   localparam int DEF_CNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      ARMED = 2'd2
   } state_t;

endpackage

// File: rtl/seq_det_hist.sv
// History shift register, saturating fill counter and length-masked pattern compare.
// Raises match combinationally on the edge that would accept the final pattern bit.
module seq_det_hist
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               shift,
   input  logic               overlap,
   input  logic               data_in,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   output logic               match,
   output logic               ready
);

   logic [MAX_LEN-1:0] hist_r;
   logic [MAX_LEN-1:0] hist_nxt_s;
   logic [MAX_LEN-1:0] mask_s;
   logic [LEN_W-1:0]   fill_r;
   logic [LEN_W-1:0]   fill_nxt_s;

   // Next-state view of history/fill and the compare against the low len bits.
   always_comb begin
      hist_nxt_s = {hist_r[MAX_LEN-2:0], data_in};
      if (fill_r == LEN_W'(MAX_LEN)) begin
         fill_nxt_s = fill_r;
      end else begin
         fill_nxt_s = fill_r + LEN_W'(1);
      end
      mask_s = {MAX_LEN{1'b0}};
      for (int i = 0; i < MAX_LEN; i++) begin
         mask_s[i] = (i < int'(len));
      end
      ready = shift && (len != {LEN_W{1'b0}}) && (fill_nxt_s >= len);
      match = ready && (((hist_nxt_s ^ pattern) & mask_s) == {MAX_LEN{1'b0}});
   end

   // History and fill registers; non-overlap matches restart the fill count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_r <= {MAX_LEN{1'b0}};
         fill_r <= {LEN_W{1'b0}};
      end else if (clear) begin
         hist_r <= {MAX_LEN{1'b0}};
         fill_r <= {LEN_W{1'b0}};
      end else if (shift) begin
         hist_r <= hist_nxt_s;
         if (match && !overlap) begin
            fill_r <= {LEN_W{1'b0}};
         end else begin
            fill_r <= fill_nxt_s;
         end
      end else begin
         hist_r <= hist_r;
         fill_r <= fill_r;
      end
   end

endmodule

// File: rtl/seq_det_param.sv
// Configurable serial pattern detector with overlap/non-overlap modes and a registered pulse.
// Define SEQ_DET_MATCH_CNT_EN to add the saturating match_count output.
module seq_det_param
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               data_valid,
   input  logic               data_in,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
`ifdef SEQ_DET_MATCH_CNT_EN
   output logic [CNT_W-1:0]   match_count,
`endif
   output logic               detected
);

   if (MAX_LEN < 2 || MAX_LEN > 32 || CNT_W < 1) begin : g_param_check
      $error("seq_det_param: MAX_LEN must be 2..32 and CNT_W at least 1");
   end

   state_t             state_r;
   logic [MAX_LEN-1:0] pattern_r;
   logic [LEN_W-1:0]   len_r;
   logic               overlap_r;
   logic               detected_r;
   logic [LEN_W-1:0]   len_clamp_s;
   logic               shift_s;
   logic               match_s;
   logic               ready_s;

   // Oversized lengths collapse to the full history width.
   always_comb begin
      if (cfg_len > LEN_W'(MAX_LEN)) begin
         len_clamp_s = LEN_W'(MAX_LEN);
      end else begin
         len_clamp_s = cfg_len;
      end
   end

   // A configuration write swallows any data bit presented in the same cycle.
   assign shift_s = data_valid && !cfg_we;

   seq_det_hist #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_hist (
      .clk     (clk),
      .reset   (reset),
      .clear   (cfg_we),
      .shift   (shift_s),
      .overlap (overlap_r),
      .data_in (data_in),
      .pattern (pattern_r),
      .len     (len_r),
      .match   (match_s),
      .ready   (ready_s)
   );

   // Control FSM, latched configuration and the registered detect pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         pattern_r  <= {MAX_LEN{1'b0}};
         len_r      <= {LEN_W{1'b0}};
         overlap_r  <= 1'b1;
         detected_r <= 1'b0;
      end else if (cfg_we) begin
         pattern_r  <= cfg_pattern;
         len_r      <= len_clamp_s;
         overlap_r  <= cfg_overlap;
         detected_r <= 1'b0;
         if (len_clamp_s == {LEN_W{1'b0}}) begin
            state_r <= IDLE;
         end else begin
            state_r <= FILL;
         end
      end else begin
         detected_r <= match_s;
         if (data_valid) begin
            case (state_r)
               IDLE: begin
                  state_r <= IDLE;
               end
               FILL: begin
                  if (ready_s && !(match_s && !overlap_r)) begin
                     state_r <= ARMED;
                  end else begin
                     state_r <= FILL;
                  end
               end
               ARMED: begin
                  if (match_s && !overlap_r) begin
                     state_r <= FILL;
                  end else begin
                     state_r <= ARMED;
                  end
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end else begin
            state_r <= state_r;
         end
      end
   end

   assign detected = detected_r;

`ifdef SEQ_DET_MATCH_CNT_EN
   logic [CNT_W-1:0] cnt_r;

   // Saturating match counter, cleared with each new configuration.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (cfg_we) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (match_s && (cnt_r != {CNT_W{1'b1}})) begin
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign match_count = cnt_r;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Directed self-checking bench for seq_det_param (MAX_LEN=8, CNT_W=2).
// match_count checks are compiled in only with SEQ_DET_MATCH_CNT_EN.
module tb_seq_det_param;

   logic       clk;
   logic       reset;
   logic       data_valid;
   logic       data_in;
   logic       cfg_we;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       detected;
`ifdef SEQ_DET_MATCH_CNT_EN
   logic [1:0] match_count;
`endif

   int checks;
   int errors;

   seq_det_param #(
      .MAX_LEN (8),
      .CNT_W   (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .data_valid  (data_valid),
      .data_in     (data_in),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
`ifdef SEQ_DET_MATCH_CNT_EN
      .match_count (match_count),
`endif
      .detected    (detected)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_bit(input logic v, input logic b, output logic det);
      data_valid = v;
      data_in    = b;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      data_in    = 1'b0;
      det        = detected;
   endtask

   task automatic cfg_apply(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                            input logic dv, input logic di);
      cfg_we      = 1'b1;
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ov;
      data_valid  = dv;
      data_in     = di;
      @(posedge clk);
      #1;
      cfg_we     = 1'b0;
      data_valid = 1'b0;
      data_in    = 1'b0;
   endtask

   task automatic test_reset();
      logic det;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (detected !== 1'b0) begin
         errors++;
         $display("FAIL reset_detected got %b want 0", detected);
      end
`ifdef SEQ_DET_MATCH_CNT_EN
      checks++;
      if (match_count !== 2'd0) begin
         errors++;
         $display("FAIL reset_count got %0d want 0", match_count);
      end
`endif
      reset = 1'b0;
      // Unconfigured detector (len 0) must stay silent.
      for (int i = 0; i < 4; i++) begin
         drive_bit(1'b1, 1'b0, det);
         checks++;
         if (det !== 1'b0) begin
            errors++;
            $display("FAIL unconfigured_bit%0d got %b want 0", i, det);
         end
      end
   endtask

   task automatic test_overlap();
      logic [6:0] stream = 7'b1101101;
      logic [6:0] expect_v = 7'b0001001;
      logic det;
      cfg_apply(8'b0000_1101, 4'd4, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         drive_bit(1'b1, stream[6-i], det);
         checks++;
         if (det !== expect_v[6-i]) begin
            errors++;
            $display("FAIL overlap_bit%0d got %b want %b", i + 1, det, expect_v[6-i]);
         end
      end
`ifdef SEQ_DET_MATCH_CNT_EN
      checks++;
      if (match_count !== 2'd2) begin
         errors++;
         $display("FAIL overlap_count got %0d want 2", match_count);
      end
`endif
   endtask

   task automatic test_nonoverlap();
      logic [6:0] stream = 7'b1101101;
      logic [6:0] expect_v = 7'b0001000;
      logic det;
      cfg_apply(8'b0000_1101, 4'd4, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         drive_bit(1'b1, stream[6-i], det);
         checks++;
         if (det !== expect_v[6-i]) begin
            errors++;
            $display("FAIL nonoverlap_bit%0d got %b want %b", i + 1, det, expect_v[6-i]);
         end
      end
`ifdef SEQ_DET_MATCH_CNT_EN
      checks++;
      if (match_count !== 2'd1) begin
         errors++;
         $display("FAIL nonoverlap_count got %0d want 1", match_count);
      end
`endif
   endtask

   task automatic test_stall();
      logic [2:0] stream = 3'b101;
      logic det;
      cfg_apply(8'b0000_0101, 4'd3, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive_bit(1'b1, stream[2-i], det);
         checks++;
         if (det !== (i == 2)) begin
            errors++;
            $display("FAIL stall_valid%0d got %b want %b", i + 1, det, (i == 2));
         end
         for (int k = 0; k < 3; k++) begin
            drive_bit(1'b0, 1'b1, det);
            checks++;
            if (det !== 1'b0) begin
               errors++;
               $display("FAIL stall_idle%0d_%0d got %b want 0", i + 1, k, det);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] stream = 4'b1101;
      logic det;
      cfg_apply(8'b0000_1101, 4'd4, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive_bit(1'b1, stream[3-i], det);
         checks++;
         if (det !== 1'b0) begin
            errors++;
            $display("FAIL resetmid_pre%0d got %b want 0", i + 1, det);
         end
      end
      reset = 1'b1;
      #3;
      reset = 1'b0;
      drive_bit(1'b1, 1'b1, det);
      checks++;
      if (det !== 1'b0) begin
         errors++;
         $display("FAIL resetmid_noreload got %b want 0", det);
      end
      cfg_apply(8'b0000_1101, 4'd4, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive_bit(1'b1, stream[3-i], det);
         checks++;
         if (det !== (i == 3)) begin
            errors++;
            $display("FAIL resetmid_post%0d got %b want %b", i + 1, det, (i == 3));
         end
      end
      // Asynchronous clear of a live pulse, without waiting for an edge.
      reset = 1'b1;
      #2;
      checks++;
      if (detected !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got %b want 0", detected);
      end
      #2;
      reset = 1'b0;
   endtask

   task automatic test_cfg_wins();
      logic [2:0] stream = 3'b101;
      logic det;
      cfg_apply(8'b0000_1101, 4'd4, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive_bit(1'b1, stream[2-i], det);
         checks++;
         if (det !== 1'b0) begin
            errors++;
            $display("FAIL cfgwins_bit%0d got %b want 0", i + 1, det);
         end
      end
   endtask

   task automatic test_saturation();
      logic det;
      cfg_apply(8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         drive_bit(1'b1, 1'b1, det);
         checks++;
         if (det !== 1'b1) begin
            errors++;
            $display("FAIL sat_pulse%0d got %b want 1", i + 1, det);
         end
      end
`ifdef SEQ_DET_MATCH_CNT_EN
      checks++;
      if (match_count !== 2'd3) begin
         errors++;
         $display("FAIL sat_count got %0d want 3", match_count);
      end
`endif
   endtask

   task automatic test_reconfig();
      logic [6:0]  stream = 7'b1101101;
      logic [15:0] long_s = 16'b0000_0011_1011_0011;
      logic det;
      cfg_apply(8'b0000_1101, 4'd4, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive_bit(1'b1, stream[6-i], det);
      end
      cfg_apply(8'b0000_1101, 4'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         drive_bit(1'b1, stream[6-i], det);
         checks++;
         if (det !== 1'b0) begin
            errors++;
            $display("FAIL len0_bit%0d got %b want 0", i + 1, det);
         end
      end
      // Length 12 clamps to 8: only the full 8-bit window may match.
      cfg_apply(8'b1011_0011, 4'd12, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         drive_bit(1'b1, long_s[15-i], det);
         checks++;
         if (det !== (i == 15)) begin
            errors++;
            $display("FAIL clamp_bit%0d got %b want %b", i + 1, det, (i == 15));
         end
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      data_valid  = 1'b0;
      data_in     = 1'b0;
      cfg_we      = 1'b0;
      cfg_pattern = 8'd0;
      cfg_len     = 4'd0;
      cfg_overlap = 1'b0;
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_stall();
      test_reset_mid();
      test_cfg_wins();
      test_saturation();
      test_reconfig();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
